// File: rtl/if_stage_if.sv
// if_stage_if: fetch-stage bundle -- ID handshake, branch redirect bus and inst SRAM port
// master = if_stage side, slave = ID stage / SRAM side
interface if_stage_if;
  logic        ds_allowin;
  logic [32:0] br_bus;
  logic        fs_to_ds_valid;
  logic [63:0] fs_to_ds_bus;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_we;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;
  modport master (
    input  ds_allowin, br_bus, inst_sram_rdata,
    output fs_to_ds_valid, fs_to_ds_bus, inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata
  );
  modport slave (
    output ds_allowin, br_bus, inst_sram_rdata,
    input  fs_to_ds_valid, fs_to_ds_bus, inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata
  );
endinterface

// File: rtl/if_stage.sv
// if_stage: LoongArch-32 instruction fetch -- pre-IF nextpc, inst SRAM request, stall buffer, branch cancel
// Ports: clk, reset (sync, active-high); fs (if_stage_if.master): ds_allowin, br_bus {br_taken, br_target},
//   fs_to_ds_valid, fs_to_ds_bus {fs_inst, fs_pc}, inst_sram_{en,we,addr,wdata,rdata}.
// Optional: `define IF_CANCEL_CNT_EN adds fs_cancel_cnt[31:0], a count of dropped wrong-path instructions.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h1c000000
) (
  input  logic        clk,
  input  logic        reset,
  if_stage_if.master  fs
`ifdef IF_CANCEL_CNT_EN
  ,
  output logic [31:0] fs_cancel_cnt
`endif
);
  logic        fs_valid;
  logic [31:0] fs_pc;
  logic        buf_valid;
  logic [31:0] inst_buf;
  logic        br_done;
  logic        br_taken;
  logic [31:0] br_target;
  logic        to_fs_valid;
  logic        fs_ready_go;
  logic        fs_allowin;
  logic        redirect;
  logic        sram_en;
  logic [31:0] seq_pc;
  logic [31:0] nextpc;
  logic [31:0] fs_inst;

  assign {br_taken, br_target} = fs.br_bus;
  assign to_fs_valid = ~reset;
  assign seq_pc      = fs_pc + 32'd4;
  // br_done masks a branch whose target is already fetched while the branch still sits in ID
  assign redirect    = br_taken & ~br_done;
  assign nextpc      = redirect ? br_target : seq_pc;
  assign fs_ready_go = 1'b1;
  assign fs_allowin  = ~fs_valid | (fs_ready_go & fs.ds_allowin);
  assign sram_en     = to_fs_valid & fs_allowin;
  // SRAM data is only valid the cycle after a request, so a stalled instruction is replayed from the buffer
  assign fs_inst     = buf_valid ? inst_buf : fs.inst_sram_rdata;

  assign fs.inst_sram_en    = sram_en;
  assign fs.inst_sram_we    = 4'h0;
  assign fs.inst_sram_addr  = nextpc;
  assign fs.inst_sram_wdata = 32'h0;
  assign fs.fs_to_ds_valid  = fs_valid & fs_ready_go & ~redirect;
  assign fs.fs_to_ds_bus    = {fs_inst, fs_pc};

  always_ff @(posedge clk) begin
    if (reset) begin
      fs_valid  <= 1'b0;
      fs_pc     <= RESET_PC - 32'd4;
      buf_valid <= 1'b0;
      inst_buf  <= 32'h0;
      br_done   <= 1'b0;
    end else begin
      if (sram_en) begin
        fs_valid <= 1'b1;
        fs_pc    <= nextpc;
      end
      if (sram_en) buf_valid <= 1'b0;
      else if (fs_valid & ~buf_valid & ~fs.ds_allowin) begin
        buf_valid <= 1'b1;
        inst_buf  <= fs.inst_sram_rdata;
      end
      if (fs.ds_allowin) br_done <= 1'b0;
      else if (sram_en & redirect) br_done <= 1'b1;
    end
  end

`ifdef IF_CANCEL_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) fs_cancel_cnt <= 32'h0;
    else if (fs_valid & redirect & fs.ds_allowin) fs_cancel_cnt <= fs_cancel_cnt + 32'd1;
  end
`endif
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed and randomized checks of if_stage against an in-order delivery model
module tb_if_stage;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] key = 32'h0;
  int          n_cmp = 0;
  int          n_bad = 0;
`ifdef IF_CANCEL_CNT_EN
  logic [31:0] cnt;
`endif

  if_stage_if bus();

  if_stage #(.RESET_PC(32'h1c000000)) dut (
    .clk(clk),
    .reset(reset),
    .fs(bus.master)
`ifdef IF_CANCEL_CNT_EN
    ,
    .fs_cancel_cnt(cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ key;
  endfunction

  // synchronous SRAM: data one cycle after an enabled request, garbage otherwise
  always @(posedge clk) bus.inst_sram_rdata <= bus.inst_sram_en ? mem_word(bus.inst_sram_addr) : $urandom;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    key = 32'h0;
    bus.ds_allowin = 1'b1;
    bus.br_bus = 33'h0;
    step;
    step;
    smp;
    n_cmp++; if (bus.fs_to_ds_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got %b exp 0", bus.fs_to_ds_valid); end
    n_cmp++; if (bus.inst_sram_en !== 1'b0) begin n_bad++; $display("FAIL rst_en got %b exp 0", bus.inst_sram_en); end
    n_cmp++; if ({bus.inst_sram_we, bus.inst_sram_wdata} !== 36'h0) begin n_bad++; $display("FAIL rst_we_wdata got %h exp 0", {bus.inst_sram_we, bus.inst_sram_wdata}); end
    step;
    reset = 1'b0;
  endtask

  task automatic test_seq;
    smp;
    n_cmp++; if ({bus.inst_sram_en, bus.inst_sram_addr} !== {1'b1, 32'h1c000000}) begin n_bad++; $display("FAIL seq_addr0 got %h exp 11c000000", {bus.inst_sram_en, bus.inst_sram_addr}); end
    n_cmp++; if (bus.fs_to_ds_valid !== 1'b0) begin n_bad++; $display("FAIL seq_valid0 got %b exp 0", bus.fs_to_ds_valid); end
    step;
    smp;
    n_cmp++; if (bus.inst_sram_addr !== 32'h1c000004) begin n_bad++; $display("FAIL seq_addr1 got %h exp 1c000004", bus.inst_sram_addr); end
    n_cmp++; if ({bus.fs_to_ds_valid, bus.fs_to_ds_bus} !== {1'b1, 32'h1c000000, 32'h1c000000}) begin n_bad++; $display("FAIL seq_out1 got %h exp 1_1c000000_1c000000", {bus.fs_to_ds_valid, bus.fs_to_ds_bus}); end
    step;
    smp;
    n_cmp++; if (bus.inst_sram_addr !== 32'h1c000008) begin n_bad++; $display("FAIL seq_addr2 got %h exp 1c000008", bus.inst_sram_addr); end
    n_cmp++; if (bus.fs_to_ds_bus !== {32'h1c000004, 32'h1c000004}) begin n_bad++; $display("FAIL seq_out2 got %h exp 1c000004_1c000004", bus.fs_to_ds_bus); end
    step;
  endtask

  task automatic test_stall;
    bus.ds_allowin = 1'b0;
    for (int i = 0; i < 5; i++) begin
      smp;
      n_cmp++; if ({bus.inst_sram_en, bus.fs_to_ds_valid, bus.fs_to_ds_bus} !== {1'b0, 1'b1, 32'h1c000008, 32'h1c000008}) begin
        n_bad++; $display("FAIL stall_hold%0d got %h exp 1_1c000008_1c000008 en=0", i, {bus.inst_sram_en, bus.fs_to_ds_valid, bus.fs_to_ds_bus});
      end
      step;
    end
    bus.ds_allowin = 1'b1;
    smp;
    n_cmp++; if ({bus.inst_sram_en, bus.inst_sram_addr} !== {1'b1, 32'h1c00000c}) begin n_bad++; $display("FAIL stall_release got %h exp 11c00000c", {bus.inst_sram_en, bus.inst_sram_addr}); end
    n_cmp++; if (bus.fs_to_ds_bus !== {32'h1c000008, 32'h1c000008}) begin n_bad++; $display("FAIL stall_release_out got %h exp 1c000008_1c000008", bus.fs_to_ds_bus); end
    step;
    smp;
    n_cmp++; if (bus.fs_to_ds_bus !== {32'h1c00000c, 32'h1c00000c}) begin n_bad++; $display("FAIL stall_next got %h exp 1c00000c_1c00000c", bus.fs_to_ds_bus); end
    step;
  endtask

  task automatic test_branch;
    bus.br_bus = {1'b1, 32'h1c000100};
    smp;
    n_cmp++; if (bus.fs_to_ds_valid !== 1'b0) begin n_bad++; $display("FAIL br_cancel got %b exp 0", bus.fs_to_ds_valid); end
    n_cmp++; if ({bus.inst_sram_en, bus.inst_sram_addr, bus.fs_to_ds_bus[31:0]} !== {1'b1, 32'h1c000100, 32'h1c000010}) begin
      n_bad++; $display("FAIL br_fetch got %h exp 1_1c000100_1c000010", {bus.inst_sram_en, bus.inst_sram_addr, bus.fs_to_ds_bus[31:0]});
    end
    step;
    bus.br_bus = 33'h0;
    smp;
    n_cmp++; if ({bus.fs_to_ds_valid, bus.fs_to_ds_bus} !== {1'b1, 32'h1c000100, 32'h1c000100}) begin n_bad++; $display("FAIL br_target got %h exp 1_1c000100_1c000100", {bus.fs_to_ds_valid, bus.fs_to_ds_bus}); end
    step;
  endtask

  task automatic test_br_done;
    int fetches;
    fetches = 0;
    reset = 1'b1;
    step;
    reset = 1'b0;
    bus.ds_allowin = 1'b0;
    bus.br_bus = {1'b1, 32'h1c000200};
    for (int i = 0; i < 3; i++) begin
      smp;
      if (bus.inst_sram_en) fetches++;
      if (i == 0) begin
        n_cmp++; if (bus.inst_sram_addr !== 32'h1c000200) begin n_bad++; $display("FAIL brd_addr got %h exp 1c000200", bus.inst_sram_addr); end
      end else begin
        n_cmp++; if ({bus.fs_to_ds_valid, bus.fs_to_ds_bus} !== {1'b1, 32'h1c000200, 32'h1c000200}) begin
          n_bad++; $display("FAIL brd_hold%0d got %h exp 1_1c000200_1c000200", i, {bus.fs_to_ds_valid, bus.fs_to_ds_bus});
        end
      end
      step;
    end
    n_cmp++; if (fetches != 1) begin n_bad++; $display("FAIL brd_fetches got %0d exp 1", fetches); end
    bus.ds_allowin = 1'b1;
    smp;
    n_cmp++; if ({bus.fs_to_ds_valid, bus.fs_to_ds_bus} !== {1'b1, 32'h1c000200, 32'h1c000200}) begin n_bad++; $display("FAIL brd_deliver got %h exp 1_1c000200_1c000200", {bus.fs_to_ds_valid, bus.fs_to_ds_bus}); end
    n_cmp++; if ({bus.inst_sram_en, bus.inst_sram_addr} !== {1'b1, 32'h1c000204}) begin n_bad++; $display("FAIL brd_next got %h exp 11c000204", {bus.inst_sram_en, bus.inst_sram_addr}); end
    step;
    bus.br_bus = 33'h0;
    smp;
    n_cmp++; if ({bus.fs_to_ds_valid, bus.fs_to_ds_bus[31:0]} !== {1'b1, 32'h1c000204}) begin n_bad++; $display("FAIL brd_after got %h exp 11c000204", {bus.fs_to_ds_valid, bus.fs_to_ds_bus[31:0]}); end
    step;
  endtask

  task automatic test_reset_mid;
    bus.ds_allowin = 1'b0;
    step;
    step;
    reset = 1'b1;
    key = 32'h0f0f0000;
    step;
    smp;
    n_cmp++; if ({bus.fs_to_ds_valid, bus.inst_sram_en} !== 2'b00) begin n_bad++; $display("FAIL rmid_clear got %b exp 00", {bus.fs_to_ds_valid, bus.inst_sram_en}); end
    step;
    reset = 1'b0;
    bus.ds_allowin = 1'b1;
    smp;
    n_cmp++; if ({bus.inst_sram_en, bus.inst_sram_addr} !== {1'b1, 32'h1c000000}) begin n_bad++; $display("FAIL rmid_addr got %h exp 11c000000", {bus.inst_sram_en, bus.inst_sram_addr}); end
    step;
    smp;
    n_cmp++; if ({bus.fs_to_ds_valid, bus.fs_to_ds_bus} !== {1'b1, 32'h130f0000, 32'h1c000000}) begin n_bad++; $display("FAIL rmid_first got %h exp 1_130f0000_1c000000", {bus.fs_to_ds_valid, bus.fs_to_ds_bus}); end
    step;
  endtask

`ifdef IF_CANCEL_CNT_EN
  task automatic test_cancel_cnt;
    reset = 1'b1;
    bus.br_bus = 33'h0;
    step;
    reset = 1'b0;
    bus.ds_allowin = 1'b1;
    step;
    step;
    for (int i = 0; i < 3; i++) begin
      bus.br_bus = {1'b1, 32'h1c001000 + 32'h100 * i};
      step;
      bus.br_bus = 33'h0;
      step;
      step;
    end
    smp;
    n_cmp++; if (cnt !== 32'd3) begin n_bad++; $display("FAIL cancel_cnt got %0d exp 3", cnt); end
    step;
  endtask
`endif

  // model: ID accepts instructions in program order; a taken branch resets the expected PC to its target,
  // and the branch leaves ID in the first cycle ID allows in
  task automatic test_random;
    logic [31:0] exp_pc;
    logic [31:0] tgt;
    logic        br_active;
    logic        allow;
    int          deliveries;
    int          cancels;
    reset = 1'b1;
    key = $urandom;
    bus.br_bus = 33'h0;
    step;
    reset = 1'b0;
    exp_pc = 32'h1c000000;
    tgt = 32'h0;
    br_active = 1'b0;
    deliveries = 0;
    cancels = 0;
    for (int c = 0; c < 3000; c++) begin
      allow = ($urandom % 4) != 0;
      if (!br_active && c > 3 && ($urandom % 8) == 0) begin
        br_active = 1'b1;
        tgt = 32'h1c000000 + ($urandom & 32'h000ffffc);
        exp_pc = tgt;
      end
      bus.ds_allowin = allow;
      bus.br_bus = {br_active, tgt};
      smp;
      if (bus.fs_to_ds_valid && allow) begin
        n_cmp++; if (bus.fs_to_ds_bus !== {mem_word(exp_pc), exp_pc}) begin n_bad++; $display("FAIL rnd_deliver cyc %0d got %h exp %h", c, bus.fs_to_ds_bus, {mem_word(exp_pc), exp_pc}); end
        exp_pc = exp_pc + 32'd4;
        deliveries++;
      end
      if (br_active && allow) begin
        if (!bus.fs_to_ds_valid) cancels++;
        br_active = 1'b0;
      end
      step;
    end
    bus.br_bus = 33'h0;
    n_cmp++; if (deliveries < 1200) begin n_bad++; $display("FAIL rnd_progress got %0d deliveries exp >= 1200", deliveries); end
`ifdef IF_CANCEL_CNT_EN
    smp;
    n_cmp++; if (cnt !== 32'(cancels)) begin n_bad++; $display("FAIL rnd_cancel_cnt got %0d exp %0d", cnt, cancels); end
    step;
`endif
  endtask

  initial begin
    bus.ds_allowin = 1'b1;
    bus.br_bus = 33'h0;
    test_reset;
    test_seq;
    test_stall;
    test_branch;
    test_br_done;
    test_reset_mid;
`ifdef IF_CANCEL_CNT_EN
    test_cancel_cnt;
`endif
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage LoongArch-32 pipeline, upstream of id_stage.
- Generates the next PC (pre-IF), drives the synchronous inst SRAM, and holds the fetched instruction.
- Delivers {inst, pc} to ID over the valid/allowin handshake.
- Consumes br_bus from ID to redirect fetch and cancel the wrong-path instruction.

Parameters:
- RESET_PC, 32'h1c000000, address of first fetched instruction.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- ds_allowin  input  1  ID can accept an instruction this cycle
- br_bus  input  33  {br_taken[32], br_target[31:0]} from ID; br_taken may stay high for several cycles while ID stalls
- fs_to_ds_valid  output  1  fs_to_ds_bus valid to ID
- fs_to_ds_bus  output  64  {fs_inst[63:32], fs_pc[31:0]}
- inst_sram_en  output  1  read enable
- inst_sram_we  output  4  byte write enables, tied 4'h0
- inst_sram_addr  output  32  fetch address (= nextpc)
- inst_sram_wdata  output  32  tied 32'h0
- inst_sram_rdata  input  32  read data; valid only in the cycle after an enabled request

Behaviour:
- Reset values: fs_valid=0, fs_pc=RESET_PC-4 (so seq_pc=RESET_PC), inst buffer empty, br_done=0, fs_to_ds_valid=0.
  - inst_sram_en may assert in the first cycle after reset deasserts.
- pre-IF:
  - to_fs_valid = ~reset.
  - seq_pc = fs_pc+4, 32-bit wrap.
  - redirect = br_taken & ~br_done.
  - nextpc = redirect ? br_target : seq_pc.
- Handshake:
  - fs_ready_go=1.
  - fs_allowin = ~fs_valid | (fs_ready_go & ds_allowin).
  - inst_sram_en = to_fs_valid & fs_allowin; inst_sram_addr = nextpc.
  - When inst_sram_en=1: fs_valid<=1 and fs_pc<=nextpc at the clock edge.
  - Instruction arrives on rdata the next cycle, giving one-cycle fetch latency.
- Output:
  - fs_to_ds_valid = fs_valid & fs_ready_go & ~redirect.
  - fs_inst = buf_valid ? inst_buf : inst_sram_rdata.
- Instruction buffer (stall hold):
  - If fs_valid & ~buf_valid & ~ds_allowin, capture inst_sram_rdata into inst_buf and set buf_valid.
  - Clear buf_valid when the stage accepts a new fetch (inst_sram_en=1).
  - The instruction delivered after any stall length equals the word read at fs_pc.
- Cancel (wrong path):
  - While redirect=1, the IF instruction is never forwarded.
  - When ds_allowin=1 with redirect=1, the IF instruction is dropped and the fetch of br_target issues the same cycle.
- br_done:
  - Set when inst_sram_en=1, redirect=1 and ds_allowin=0. This is the case where the branch target was fetched while the branch is still held in ID, e.g. fs_valid=0.
  - Clear when ds_allowin=1, i.e. the branch has left ID.
  - Prevents a correct-path target instruction from being cancelled or re-fetched.
- Simultaneous events:
  - redirect and buffer capture in the same cycle: buffer content is irrelevant because the instruction is cancelled.
  - Buffer is cleared on the next fetch.
- Reset mid-operation: all state returns to reset values next edge; any pending SRAM data is ignored.

Optional Feature:
- Macro: IF_CANCEL_CNT_EN.
- Defined:
  - Adds output fs_cancel_cnt[31:0], reset 0.
  - Increments by 1 (wrapping) in each cycle where fs_valid & redirect & ds_allowin, i.e. a wrong-path instruction is dropped.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset release, ds_allowin=1, SRAM returns addr-as-data -> addrs 1c000000, 1c000004, 1c000008 on consecutive cycles; fs_to_ds_bus={1c000000,1c000000} one cycle after first en.
- ds_allowin=0 for 5 cycles with fs_pc=1c000008 -> inst_sram_en=0, fs_to_ds_bus held at {1c000008,1c000008} with rdata driven to garbage; on release next addr=1c00000c.
- br_bus={1,1c000100} one cycle with ds_allowin=1, fs_pc=1c000010 -> fs_to_ds_valid=0 that cycle, inst_sram_addr=1c000100; next delivered pc=1c000100.
- br_taken held 3 cycles with ds_allowin=0 and fs_valid=0 -> exactly one fetch at 1c000200 (br_done=1), no re-fetch; after ds_allowin=1, 1c000200 is delivered, not cancelled, and next addr=1c000204.
- Reset asserted mid-stall with buf_valid=1 -> next cycle fs_valid=0, buf_valid=0; first fetch after release at 1c000000.
- IF_CANCEL_CNT_EN defined, run three cancelling branches -> fs_cancel_cnt=3.
